// File: rtl/reg_file_write_32_pkg.sv
// ---------------------------------------------------------------------------
// reg_file_write_32_pkg
//   Shared constants for the 32 x 32-bit register file write side, plus the
//   saturating increment used by the committed-write counter.
// ---------------------------------------------------------------------------
package reg_file_write_32_pkg;

    localparam int RF_DATA_W   = 32;   // register width
    localparam int RF_ADDR_W   = 5;    // write-address width
    localparam int RF_NUM_REGS = 32;   // register count, equals 2**RF_ADDR_W
    localparam int WR_COUNT_W  = 16;   // committed-write counter width

    localparam logic [RF_ADDR_W-1:0] REG_ZERO = 5'd0;  // hardwired-zero index

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [WR_COUNT_W-1:0] sat_inc(input logic [WR_COUNT_W-1:0] v);
        return (v == '1) ? v : v + WR_COUNT_W'(1);
    endfunction

endpackage

// File: rtl/reg_file_write_32_if.sv
// ---------------------------------------------------------------------------
// reg_file_write_32_if
//   Single write port of the register file.
//     we    : write enable for this cycle
//     waddr : destination register index
//     wdata : write data
//   master drives the port, slave (the register file) receives it.
// ---------------------------------------------------------------------------
interface reg_file_write_32_if
    import reg_file_write_32_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
);
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;

    modport master (output we, output waddr, output wdata);
    modport slave  (input  we, input  waddr, input  wdata);
endinterface

// File: rtl/reg_file_write_32_decoder.sv
// ---------------------------------------------------------------------------
// decoder_5_32
//   5-to-32 one-hot decoder with enable.
//     en_i     : enable; output is all zeros when low
//     addr_i   : 5-bit index
//     onehot_o : bit addr_i set when enabled
// ---------------------------------------------------------------------------
module decoder_5_32
    import reg_file_write_32_pkg::*;
(
    input  logic                   en_i,
    input  logic [RF_ADDR_W-1:0]   addr_i,
    output logic [RF_NUM_REGS-1:0] onehot_o
);

    always_comb begin
        // NOTE: assign a default before the conditional so no path leaves
        // onehot_o unassigned; otherwise a latch is inferred.
        onehot_o = '0;
        if (en_i) begin
            onehot_o[addr_i] = 1'b1;
        end
    end

endmodule

// File: rtl/reg_file_write_32.sv
// ---------------------------------------------------------------------------
// reg_file_write_32
//   Write side of the 32 x 32-bit register file. Holds registers r1..r31,
//   ties r0 to zero, and presents every register on its own output for the
//   read multiplexers. Also counts committed writes (saturating at 16'hFFFF).
//
//   Ports
//     clk      : clock, all state changes on the rising edge
//     rst      : synchronous, active-high reset of all registers and counter
//     wbus     : write port (we, waddr, wdata), slave side
//     r0..r31  : register contents
//     wr_count : committed writes to r1..r31 since reset
//
//   Build option
//     REGFILE_BYPASS_EN : when defined, a register being written this cycle
//                         shows wdata combinationally (write-before-read);
//                         r0 is never bypassed. Undefined: outputs are
//                         purely registered.
//
//   NUM_REGS must equal 2**ADDR_W; the output list is fixed at 32 registers.
// ---------------------------------------------------------------------------
module reg_file_write_32
    import reg_file_write_32_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int NUM_REGS = RF_NUM_REGS
)(
    input  logic                    clk,
    input  logic                    rst,
    reg_file_write_32_if.slave      wbus,
    output logic [DATA_W-1:0]       r0,  r1,  r2,  r3,  r4,  r5,  r6,  r7,
    output logic [DATA_W-1:0]       r8,  r9,  r10, r11, r12, r13, r14, r15,
    output logic [DATA_W-1:0]       r16, r17, r18, r19, r20, r21, r22, r23,
    output logic [DATA_W-1:0]       r24, r25, r26, r27, r28, r29, r30, r31,
    output logic [WR_COUNT_W-1:0]   wr_count
);

    logic [NUM_REGS-1:0]   dec_line;
    logic [NUM_REGS-1:0]   wr_line;
    logic [DATA_W-1:0]     reg_val [NUM_REGS];
    logic [WR_COUNT_W-1:0] wr_count_q;
    logic [WR_COUNT_W-1:0] wr_count_d;

    decoder_5_32 u_decoder (
        .en_i     (wbus.we),
        .addr_i   (wbus.waddr),
        .onehot_o (dec_line)
    );

    // Writes to r0 are silently discarded: its strobe never fires, so it is
    // neither stored nor counted.
    assign wr_line = dec_line & ~(NUM_REGS'(1) << REG_ZERO);

    assign reg_val[0] = '0;

    for (genvar k = 1; k < NUM_REGS; k++) begin : g_reg
        logic [DATA_W-1:0] reg_q;
        logic [DATA_W-1:0] reg_d;

        assign reg_d = wr_line[k] ? wbus.wdata : reg_q;

        // NOTE: every architectural register clears on reset (registers,
        // not an inferred RAM), and sequential state uses non-blocking
        // assignment so all registers sample the same pre-edge values.
        always_ff @(posedge clk) begin
            if (rst) begin
                reg_q <= '0;
            end else begin
                reg_q <= reg_d;
            end
        end

`ifdef REGFILE_BYPASS_EN
        // A simultaneous reset wins, so the bypass is suppressed under rst.
        assign reg_val[k] = (wr_line[k] && !rst) ? wbus.wdata : reg_q;
`else
        assign reg_val[k] = reg_q;
`endif
    end

    assign wr_count_d = (|wr_line) ? sat_inc(wr_count_q) : wr_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_count_q <= '0;
        end else begin
            wr_count_q <= wr_count_d;
        end
    end

    assign wr_count = wr_count_q;

    assign r0  = reg_val[0];   assign r1  = reg_val[1];
    assign r2  = reg_val[2];   assign r3  = reg_val[3];
    assign r4  = reg_val[4];   assign r5  = reg_val[5];
    assign r6  = reg_val[6];   assign r7  = reg_val[7];
    assign r8  = reg_val[8];   assign r9  = reg_val[9];
    assign r10 = reg_val[10];  assign r11 = reg_val[11];
    assign r12 = reg_val[12];  assign r13 = reg_val[13];
    assign r14 = reg_val[14];  assign r15 = reg_val[15];
    assign r16 = reg_val[16];  assign r17 = reg_val[17];
    assign r18 = reg_val[18];  assign r19 = reg_val[19];
    assign r20 = reg_val[20];  assign r21 = reg_val[21];
    assign r22 = reg_val[22];  assign r23 = reg_val[23];
    assign r24 = reg_val[24];  assign r25 = reg_val[25];
    assign r26 = reg_val[26];  assign r27 = reg_val[27];
    assign r28 = reg_val[28];  assign r29 = reg_val[29];
    assign r30 = reg_val[30];  assign r31 = reg_val[31];

endmodule

// File: tb/tb_reg_file_write_32.sv
// ---------------------------------------------------------------------------
// tb_reg_file_write_32
//   Drives directed and random write traffic into reg_file_write_32. A
//   behavioural model (array of 32 words plus an integer count) predicts the
//   visible outputs for each cycle; the predictions are queued and a
//   separate monitor compares them against the DUT on the falling edge.
// ---------------------------------------------------------------------------
module tb_reg_file_write_32;

    logic        clk;
    logic        rst;
    logic [31:0] r_out [32];
    logic [15:0] wr_count;

    reg_file_write_32_if wif ();

    reg_file_write_32 dut (
        .clk (clk), .rst (rst), .wbus (wif),
        .r0  (r_out[0]),  .r1  (r_out[1]),  .r2  (r_out[2]),  .r3  (r_out[3]),
        .r4  (r_out[4]),  .r5  (r_out[5]),  .r6  (r_out[6]),  .r7  (r_out[7]),
        .r8  (r_out[8]),  .r9  (r_out[9]),  .r10 (r_out[10]), .r11 (r_out[11]),
        .r12 (r_out[12]), .r13 (r_out[13]), .r14 (r_out[14]), .r15 (r_out[15]),
        .r16 (r_out[16]), .r17 (r_out[17]), .r18 (r_out[18]), .r19 (r_out[19]),
        .r20 (r_out[20]), .r21 (r_out[21]), .r22 (r_out[22]), .r23 (r_out[23]),
        .r24 (r_out[24]), .r25 (r_out[25]), .r26 (r_out[26]), .r27 (r_out[27]),
        .r28 (r_out[28]), .r29 (r_out[29]), .r30 (r_out[30]), .r31 (r_out[31]),
        .wr_count (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard entry: idx 0..31 selects a register, 32 selects wr_count.
    typedef struct {
        int          idx;
        logic [31:0] exp;
    } chk_t;

    chk_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state.
    logic [31:0] m_regs [32];
    int          m_count;

    // Monitor: compares every queued prediction on the falling edge.
    initial begin : monitor
        chk_t        c;
        logic [31:0] act;
        forever begin
            @(negedge clk);
            while (sb.size() > 0) begin
                c   = sb.pop_front();
                act = (c.idx == 32) ? {16'h0, wr_count} : r_out[c.idx];
                n_checks++;
                if (act !== c.exp) begin
                    n_fail++;
                    if (c.idx == 32)
                        $display("FAIL wr_count @%0t: got %h expected %h", $time, act, c.exp);
                    else
                        $display("FAIL r%0d @%0t: got %h expected %h", c.idx, $time, act, c.exp);
                end
            end
        end
    end

    // Queue the outputs the DUT should show during this cycle, given the
    // model state and the inputs currently applied.
    task automatic push_checks(input bit r, input bit w, input logic [4:0] a,
                               input logic [31:0] d, input bit all_regs);
        chk_t c;
        if (all_regs) begin
            for (int k = 0; k < 32; k++) begin
                c.idx = k;
                c.exp = m_regs[k];
`ifdef REGFILE_BYPASS_EN
                if (!r && w && a == 5'(k) && k != 0) c.exp = d;
`endif
                sb.push_back(c);
            end
        end
        c.idx = 32;
        c.exp = 32'(m_count);
        sb.push_back(c);
    endtask

    // Apply one cycle of stimulus, then advance the model across the edge.
    task automatic step(input bit r, input bit w, input logic [4:0] a,
                        input logic [31:0] d, input bit chk, input bit all_regs);
        rst       = r;
        wif.we    = w;
        wif.waddr = a;
        wif.wdata = d;
        if (chk) push_checks(r, w, a, d, all_regs);
        @(posedge clk);
        if (r) begin
            for (int k = 0; k < 32; k++) m_regs[k] = 32'h0;
            m_count = 0;
        end else if (w && a != 5'd0) begin
            m_regs[a] = d;
            if (m_count < 65535) m_count++;
        end
        #1;
    endtask

    initial begin : stimulus
        for (int k = 0; k < 32; k++) m_regs[k] = 32'h0;
        m_count = 0;

        // Reset held two cycles with a competing write to r5.
        step(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b1);
        step(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 1'b1);

        // Write sweep r1..r31.
        for (int k = 1; k < 32; k++)
            step(1'b0, 1'b1, 5'(k), 32'hA5A50000 + 32'(k), 1'b1, 1'b1);
        step(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1);

        // Write to the zero register is discarded and not counted.
        step(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 1'b1);
        step(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1);

        // Overwrite r7 back-to-back, then a disabled write.
        step(1'b0, 1'b1, 5'd7, 32'h1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 5'd7, 32'h2, 1'b1, 1'b1);
        step(1'b0, 1'b0, 5'd7, 32'h3, 1'b1, 1'b1);
        step(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1);

        // Reset mid-stream drops the simultaneous write.
        step(1'b0, 1'b1, 5'd3, 32'h11, 1'b1, 1'b1);
        step(1'b1, 1'b1, 5'd4, 32'h22, 1'b1, 1'b1);
        step(1'b0, 1'b1, 5'd4, 32'h33, 1'b1, 1'b1);
        step(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1);

        // Same-cycle visibility of a write to r9 (old value unless bypassed).
        step(1'b0, 1'b1, 5'd9, 32'hCAFEF00D, 1'b1, 1'b1);
        step(1'b0, 1'b0, 5'd9, 32'h0, 1'b1, 1'b1);

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++)
            step(($urandom % 40) == 0, ($urandom % 4) != 0,
                 5'($urandom_range(0, 31)), $urandom, 1'b1, 1'b1);

        // Drive the counter into saturation, watching only wr_count.
        for (int i = 0; i < 65540; i++)
            step(1'b0, 1'b1, 5'($urandom_range(1, 31)), $urandom, 1'b1, 1'b0);
        step(1'b0, 1'b1, 5'd12, 32'h12345678, 1'b1, 1'b1);
        step(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1);

        // Bounded drain of any outstanding predictions.
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending entries expected 0", sb.size());
        end
        @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
